// File: rtl/oven_zone_ctrl_if.sv
// Bundle of oven panel inputs and actuator outputs shared between the
// controller (slave) and whatever drives the front panel (master).
interface oven_zone_ctrl_if #(
    parameter int TW = 8,
    parameter int DW = 8
);
    logic          start_btn_i;
    logic          pause_btn_i;
    logic          door_open_i;
    logic [1:0]    mode_sel_i;
    logic          high_grill_i;
    logic [DW-1:0] set_temp_i;
    logic [TW-1:0] set_time_i;
    logic [DW-1:0] cur_temp_i;
    logic [3:0]    hrod_o;
    logic          light_o;
    logic          fan_o;
    logic          buzzer_o;
    logic          done_o;
    logic [TW-1:0] timer_o;
    logic [2:0]    state_o;

    modport master (
        output start_btn_i, pause_btn_i, door_open_i, mode_sel_i, high_grill_i,
               set_temp_i, set_time_i, cur_temp_i,
        input  hrod_o, light_o, fan_o, buzzer_o, done_o, timer_o, state_o
    );

    modport slave (
        input  start_btn_i, pause_btn_i, door_open_i, mode_sel_i, high_grill_i,
               set_temp_i, set_time_i, cur_temp_i,
        output hrod_o, light_o, fan_o, buzzer_o, done_o, timer_o, state_o
    );
endinterface

// File: rtl/oven_zone_ctrl.sv
// Oven zone controller: mode FSM, prescaled countdown timer, hysteretic heater rods, done buzzer.
// Define OVEN_PREHEAT_WAIT_EN to hold the cooking timer until the chamber first reaches setpoint.
module oven_zone_ctrl #(
    parameter int TW        = 8,
    parameter int DW        = 8,
    parameter int PRESCALE  = 1,
    parameter int HYST      = 4,
    parameter int BUZZ_CYC  = 4,
    parameter int GRILL_DEF = 90
) (
    input logic             clk,
    input logic             rst,
    oven_zone_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PREHEAT = 3'd1;
    localparam logic [2:0] COOK    = 3'd2;
    localparam logic [2:0] GRILL   = 3'd3;
    localparam logic [2:0] BAKE    = 3'd4;
    localparam logic [2:0] PAUSE   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;

    logic [2:0]    state_q, state_d;
    logic [2:0]    retState_q, retState_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] preCnt_q, preCnt_d;
    logic [BW-1:0] buzzCnt_q, buzzCnt_d;
    logic          grillHi_q, grillHi_d;
    logic          heat_q, heat_d;
    logic [3:0]    hrod_q, hrod_d;
    logic          fan_q, fan_d;
    logic          light_q, light_d;
    logic          buzzer_q, buzzer_d;

    logic [TW-1:0] loadVal;
    logic [DW:0]   loTemp;
    logic          tempOk;
    logic          tooCold;
    logic          holdReq;
    logic          runTimer;
    logic [3:0]    rodPat;

    assign tempOk  = (bus.cur_temp_i >= bus.set_temp_i);
    assign holdReq = bus.pause_btn_i | bus.door_open_i;

    // Lower thermostat threshold saturates at zero for small setpoints
    always_comb begin
        loTemp = '0;
        if ({1'b0, bus.set_temp_i} > (DW+1)'(HYST)) begin
            loTemp = {1'b0, bus.set_temp_i} - (DW+1)'(HYST);
        end
        tooCold = ({1'b0, bus.cur_temp_i} < loTemp);
    end

`ifdef OVEN_PREHEAT_WAIT_EN
    logic ready_q, ready_d;

    assign runTimer = ready_q | tempOk;

    always_comb begin
        ready_d = ready_q | tempOk;
        if (state_q == IDLE) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= ready_d;
    end
`else
    assign runTimer = 1'b1;
`endif

    always_comb begin
        loadVal = bus.set_time_i;
        if (bus.mode_sel_i == 2'b10 && !bus.high_grill_i) begin
            loadVal = TW'(GRILL_DEF);
        end
    end

    always_comb begin
        state_d    = state_q;
        retState_d = retState_q;
        timer_d    = timer_q;
        preCnt_d   = preCnt_q;
        buzzCnt_d  = buzzCnt_q;
        grillHi_d  = grillHi_q;

        case (state_q)
            IDLE: begin
                buzzCnt_d = '0;
                if (bus.start_btn_i && !bus.door_open_i &&
                    (bus.mode_sel_i == 2'b00 || loadVal != '0)) begin
                    // mode_sel 00..11 maps directly onto PREHEAT..BAKE
                    state_d = {1'b0, bus.mode_sel_i} + 3'd1;
                    if (bus.mode_sel_i != 2'b00) begin
                        timer_d   = loadVal;
                        grillHi_d = (bus.mode_sel_i == 2'b10) && bus.high_grill_i;
                    end
                end
            end
            PREHEAT: begin
                if (holdReq) begin
                    state_d    = PAUSE;
                    retState_d = PREHEAT;
                end else if (tempOk) begin
                    state_d = DONE;
                end
            end
            COOK, GRILL, BAKE: begin
                if (holdReq) begin
                    state_d    = PAUSE;
                    retState_d = state_q;
                end else if (!runTimer) begin
                    preCnt_d = '0;
                end else if (preCnt_q == PW'(PRESCALE - 1)) begin
                    preCnt_d = '0;
                    if (timer_q != '0) timer_d = timer_q - 1'b1;
                    if (timer_q <= TW'(1)) state_d = DONE;
                end else begin
                    preCnt_d = preCnt_q + 1'b1;
                end
            end
            PAUSE: begin
                if (!holdReq) state_d = retState_q;
            end
            DONE: begin
                if (buzzCnt_q == BW'(BUZZ_CYC - 1)) begin
                    state_d   = IDLE;
                    buzzCnt_d = '0;
                end else begin
                    buzzCnt_d = buzzCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) preCnt_d = '0;
    end

    // Outputs are computed from next-state values so the registered copies line up with state_o
    always_comb begin
        heat_d = heat_q;
        if (tooCold)     heat_d = 1'b1;
        else if (tempOk) heat_d = 1'b0;

        case (state_d)
            PREHEAT: rodPat = 4'b0100;
            COOK:    rodPat = 4'b0110;
            GRILL:   rodPat = grillHi_d ? 4'b1110 : 4'b0110;
            BAKE:    rodPat = 4'b1111;
            default: rodPat = 4'b0000;
        endcase

        hrod_d   = rodPat & {4{heat_d}};
        fan_d    = (state_d == COOK) || (state_d == GRILL) ||
                   (state_d == BAKE) || (state_d == DONE);
        light_d  = !((state_d == IDLE) && !bus.door_open_i);
        buzzer_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            retState_q <= IDLE;
            timer_q    <= '0;
            preCnt_q   <= '0;
            buzzCnt_q  <= '0;
            grillHi_q  <= 1'b0;
            heat_q     <= 1'b0;
            hrod_q     <= 4'b0000;
            fan_q      <= 1'b0;
            light_q    <= 1'b1;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            retState_q <= retState_d;
            timer_q    <= timer_d;
            preCnt_q   <= preCnt_d;
            buzzCnt_q  <= buzzCnt_d;
            grillHi_q  <= grillHi_d;
            heat_q     <= heat_d;
            hrod_q     <= hrod_d;
            fan_q      <= fan_d;
            light_q    <= light_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign bus.state_o  = state_q;
    assign bus.timer_o  = timer_q;
    assign bus.hrod_o   = hrod_q;
    assign bus.fan_o    = fan_q;
    assign bus.light_o  = light_q;
    assign bus.buzzer_o = buzzer_q;
    assign bus.done_o   = buzzer_q;
endmodule

// File: tb/tb_oven_zone_ctrl.sv
// Scoreboard bench for oven_zone_ctrl with PRESCALE=2: expected output snapshots are queued
// per cycle of stimulus and popped one cycle later when the DUT has registered its response.
module tb_oven_zone_ctrl;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREHEAT = 3'd1;
    localparam logic [2:0] S_COOK    = 3'd2;
    localparam logic [2:0] S_GRILL   = 3'd3;
    localparam logic [2:0] S_BAKE    = 3'd4;
    localparam logic [2:0] S_PAUSE   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] tmr;
        logic [3:0] rod;
        logic       fan;
        logic       buz;
        logic       dn;
        logic       lit;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   nTests = 0;
    int   nFail  = 0;
    exp_t sb[$];
    exp_t e, o;

    oven_zone_ctrl_if #(.TW(8), .DW(8)) bus ();

    oven_zone_ctrl #(
        .TW(8), .DW(8), .PRESCALE(2), .HYST(4), .BUZZ_CYC(4), .GRILL_DEF(90)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [2:0] st, logic [7:0] tmr, logic [3:0] rod,
                                logic fan, logic buz, logic lit);
        return {st, tmr, rod, fan, buz, buz, lit};
    endfunction

    function automatic exp_t observe();
        return {bus.state_o, bus.timer_o, bus.hrod_o, bus.fan_o,
                bus.buzzer_o, bus.done_o, bus.light_o};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleInputs();
        bus.start_btn_i  = 1'b0;
        bus.pause_btn_i  = 1'b0;
        bus.door_open_i  = 1'b0;
        bus.mode_sel_i   = 2'b00;
        bus.high_grill_i = 1'b0;
        bus.set_temp_i   = 8'd0;
        bus.set_time_i   = 8'd0;
        bus.cur_temp_i   = 8'd0;
    endtask

    task automatic resetDut();
        idleInputs();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        step(2);
        o = observe();
        e = mk(S_IDLE, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        nTests++;
        if (o !== e) begin
            nFail++;
            $display("[TB] FAIL reset: got %p, want %p", o, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_cook_countdown();
        resetDut();
        bus.mode_sel_i = 2'b01;
        bus.set_time_i = 8'd3;
        for (int i = 0; i < 6; i++) sb.push_back(mk(S_COOK, 8'(3 - i / 2), 4'b0000, 1, 0, 1));
        for (int i = 0; i < 4; i++) sb.push_back(mk(S_DONE, 8'd0, 4'b0000, 1, 1, 1));
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 0));
        for (int k = 0; sb.size() > 0; k++) begin
            bus.start_btn_i = (k == 0);
            step(1);
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL cook_countdown step %0d: got %p, want %p", k, o, e);
            end
        end
    endtask

    task automatic test_bake_door();
        resetDut();
        bus.mode_sel_i = 2'b11;
        bus.set_time_i = 8'd5;
        bus.set_temp_i = 8'd200;
        bus.cur_temp_i = 8'd100;
        sb.push_back(mk(S_BAKE, 8'd5, 4'b1111, 1, 0, 1));
        for (int i = 0; i < 10; i++) sb.push_back(mk(S_PAUSE, 8'd5, 4'b0000, 0, 0, 1));
        for (int j = 0; j < 5; j++) sb.push_back(mk(S_BAKE, 8'(5 - j / 2), 4'b1111, 1, 0, 1));
        for (int k = 0; sb.size() > 0; k++) begin
            bus.start_btn_i = (k == 0);
            bus.door_open_i = (k >= 1 && k <= 10);
            step(1);
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL bake_door step %0d: got %p, want %p", k, o, e);
            end
        end
    endtask

    task automatic test_grill_load();
        for (int h = 0; h < 2; h++) begin
            resetDut();
            bus.mode_sel_i   = 2'b10;
            bus.high_grill_i = (h == 1);
            bus.set_time_i   = 8'd7;
            bus.set_temp_i   = 8'd200;
            bus.cur_temp_i   = 8'd100;
            if (h == 0) sb.push_back(mk(S_GRILL, 8'd90, 4'b0110, 1, 0, 1));
            else        sb.push_back(mk(S_GRILL, 8'd7, 4'b1110, 1, 0, 1));
            bus.start_btn_i = 1'b1;
            step(1);
            bus.start_btn_i = 1'b0;
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL grill_load hi=%0d: got %p, want %p", h, o, e);
            end
        end
    endtask

    task automatic test_thermostat();
        logic [7:0] temps [5];
        logic [3:0] rods  [5];
        temps = '{8'd95, 8'd97, 8'd100, 8'd97, 8'd95};
        rods  = '{4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0110};
        resetDut();
        bus.mode_sel_i = 2'b01;
        bus.set_time_i = 8'd200;
        bus.set_temp_i = 8'd100;
        for (int i = 0; i < 5; i++) sb.push_back(mk(S_COOK, 8'(200 - i / 2), rods[i], 1, 0, 1));
        for (int k = 0; sb.size() > 0; k++) begin
            bus.start_btn_i = (k == 0);
            bus.cur_temp_i  = temps[k];
            step(1);
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL thermostat cur=%0d: got %p, want %p", temps[k], o, e);
            end
        end
    endtask

    task automatic test_pause_at_expiry();
        resetDut();
        bus.mode_sel_i = 2'b01;
        bus.set_time_i = 8'd1;
        sb.push_back(mk(S_COOK, 8'd1, 4'b0000, 1, 0, 1));
        sb.push_back(mk(S_COOK, 8'd1, 4'b0000, 1, 0, 1));
        sb.push_back(mk(S_PAUSE, 8'd1, 4'b0000, 0, 0, 1));
        sb.push_back(mk(S_PAUSE, 8'd1, 4'b0000, 0, 0, 1));
        sb.push_back(mk(S_COOK, 8'd1, 4'b0000, 1, 0, 1));
        sb.push_back(mk(S_COOK, 8'd1, 4'b0000, 1, 0, 1));
        for (int i = 0; i < 4; i++) sb.push_back(mk(S_DONE, 8'd0, 4'b0000, 1, 1, 1));
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 0));
        for (int k = 0; sb.size() > 0; k++) begin
            bus.start_btn_i = (k == 0);
            bus.pause_btn_i = (k == 2 || k == 3);
            step(1);
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL pause_at_expiry step %0d: got %p, want %p", k, o, e);
            end
        end
    endtask

    task automatic test_preheat();
        resetDut();
        bus.mode_sel_i = 2'b00;
        bus.set_temp_i = 8'd100;
        for (int i = 0; i < 2; i++) sb.push_back(mk(S_PREHEAT, 8'd0, 4'b0100, 0, 0, 1));
        for (int i = 0; i < 4; i++) sb.push_back(mk(S_DONE, 8'd0, 4'b0000, 1, 1, 1));
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 0));
        for (int k = 0; sb.size() > 0; k++) begin
            bus.start_btn_i = (k < 6);
            bus.cur_temp_i  = (k < 2) ? 8'd50 : 8'd100;
            step(1);
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL preheat step %0d: got %p, want %p", k, o, e);
            end
        end
    endtask

    task automatic test_start_ignored();
        resetDut();
        bus.mode_sel_i = 2'b01;
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 0));
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 0));
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 1));
        sb.push_back(mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 0));
        for (int k = 0; sb.size() > 0; k++) begin
            bus.start_btn_i = (k < 3);
            bus.set_time_i  = (k < 2) ? 8'd0 : 8'd5;
            bus.door_open_i = (k == 2);
            step(1);
            e = sb.pop_front();
            o = observe();
            nTests++;
            if (o !== e) begin
                nFail++;
                $display("[TB] FAIL start_ignored step %0d: got %p, want %p", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        resetDut();
        bus.mode_sel_i  = 2'b01;
        bus.set_time_i  = 8'd10;
        bus.start_btn_i = 1'b1;
        step(1);
        bus.start_btn_i = 1'b0;
        step(4);
        nTests++;
        if (bus.state_o !== S_COOK || bus.timer_o !== 8'd8) begin
            nFail++;
            $display("[TB] FAIL mid_count_pre: got st=%0d tmr=%0d, want st=2 tmr=8",
                     bus.state_o, bus.timer_o);
        end
        rst = 1'b1;
        #2;
        o = observe();
        e = mk(S_IDLE, 8'd0, 4'b0000, 0, 0, 1);
        nTests++;
        if (o !== e) begin
            nFail++;
            $display("[TB] FAIL async_reset_mid_count: got %p, want %p", o, e);
        end
        step(1);
        rst = 1'b0;
    endtask

`ifdef OVEN_PREHEAT_WAIT_EN
    task automatic test_preheat_wait();
        resetDut();
        bus.mode_sel_i  = 2'b01;
        bus.set_time_i  = 8'd4;
        bus.set_temp_i  = 8'd150;
        bus.cur_temp_i  = 8'd120;
        bus.start_btn_i = 1'b1;
        step(1);
        bus.start_btn_i = 1'b0;
        step(3);
        nTests++;
        if (bus.state_o !== S_COOK || bus.timer_o !== 8'd4) begin
            nFail++;
            $display("[TB] FAIL preheat_wait_hold: got st=%0d tmr=%0d, want st=2 tmr=4",
                     bus.state_o, bus.timer_o);
        end
        bus.cur_temp_i = 8'd150;
        step(2);
        nTests++;
        if (bus.timer_o !== 8'd3) begin
            nFail++;
            $display("[TB] FAIL preheat_wait_run: got tmr=%0d, want tmr=3", bus.timer_o);
        end
        rst = 1'b1;
        #2;
        nTests++;
        if (bus.state_o !== S_IDLE || bus.timer_o !== 8'd0) begin
            nFail++;
            $display("[TB] FAIL preheat_wait_reset: got st=%0d tmr=%0d, want st=0 tmr=0",
                     bus.state_o, bus.timer_o);
        end
        step(1);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_cook_countdown();
        test_bake_door();
        test_grill_load();
        test_thermostat();
        test_pause_at_expiry();
        test_preheat();
        test_start_ignored();
        test_reset_mid_count();
`ifdef OVEN_PREHEAT_WAIT_EN
        test_preheat_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
